mem_arbiter: RTL and testbench

Two-port arbiter sharing the single synchronous program/data memory (32 x 8) between the CPU core and the program loader. It accepts one request per transaction, sequences the memory access through a three-state FSM, returns read data to the winning requester and blocks the loser until its turn. It sits between `RICS_CPU` / loader and the memory macro; all memory-side outputs are state-decoded from registers, with no combinational path from any `*_req` to `mem_*`.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous 32x8 memory between the CPU and the program loader.
// Optional `ARB_ROUND_ROBIN_EN selects alternating winners on conflicts; default is CPU priority.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

  state_t              r_state;
  state_t              w_next_state;
  owner_t              r_owner;
  owner_t              w_sel_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_any_req;
  logic                w_take;
  logic                w_access;
  logic                w_rd_resp;

  assign w_any_req = cpu_req | ldr_req;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_owner;

  // On a conflict the requester that did not win last time goes first.
  assign w_sel_owner = (cpu_req && ldr_req) ? ((r_last_owner == OWN_LDR) ? OWN_CPU : OWN_LDR)
                                            : (cpu_req ? OWN_CPU : OWN_LDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= OWN_LDR;
    end else if (w_take) begin
      r_last_owner <= w_sel_owner;
    end
  end
`else
  assign w_sel_owner = cpu_req ? OWN_CPU : OWN_LDR;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_any_req) begin
          w_take       = 1'b1;
          w_next_state = S_ACCESS;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: w_next_state = S_RESP;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_take) begin
        r_owner <= w_sel_owner;
        r_we    <= (w_sel_owner == OWN_CPU) ? cpu_we    : ldr_we;
        r_addr  <= (w_sel_owner == OWN_CPU) ? cpu_addr  : ldr_addr;
        r_wdata <= (w_sel_owner == OWN_CPU) ? cpu_wdata : ldr_wdata;
      end
    end
  end

  // Memory side is decoded purely from registers: no request reaches mem_* combinationally.
  assign w_access  = (r_state == S_ACCESS);
  assign w_rd_resp = (r_state == S_RESP) && !r_we;

  assign mem_en    = w_access;
  assign mem_we    = w_access && r_we;
  assign mem_addr  = w_access ? r_addr : '0;
  assign mem_wdata = (w_access && r_we) ? r_wdata : '0;

  assign cpu_gnt    = w_access  && (r_owner == OWN_CPU);
  assign ldr_gnt    = w_access  && (r_owner == OWN_LDR);
  assign cpu_rvalid = w_rd_resp && (r_owner == OWN_CPU);
  assign ldr_rvalid = w_rd_resp && (r_owner == OWN_LDR);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner-case sequences and randomized traffic for mem_arbiter.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory macro: synchronous 32x8, read data one cycle after a read strobe.
  logic [DW-1:0] macro_mem [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) macro_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= macro_mem[mem_addr];
    end
  end

  typedef struct packed {
    logic          rst;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          l_req, l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
  } in_t;

  typedef struct packed {
    logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
    logic [DW-1:0] cpu_rdata, ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic          v, ldr, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } grant_t;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] ref_mem [32];
  vec_t          tbl [10];

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 3) ? 8'hA5 : 8'(i * 37 + 11);
  endfunction

  function automatic in_t mk_in(input bit rst, input bit c_req, input bit c_we,
                                input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                                input bit l_req, input bit l_we,
                                input logic [AW-1:0] l_a, input logic [DW-1:0] l_d);
    in_t v;
    v.rst = rst; v.c_req = c_req; v.c_we = c_we; v.c_addr = c_a; v.c_wdata = c_d;
    v.l_req = l_req; v.l_we = l_we; v.l_addr = l_a; v.l_wdata = l_d;
    return v;
  endfunction

  function automatic out_t o_none();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_gnt(input bit is_ldr, input bit we,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
    out_t o = '0;
    o.cpu_gnt = !is_ldr; o.ldr_gnt = is_ldr;
    o.mem_en = 1'b1; o.mem_we = we; o.mem_addr = a; o.mem_wdata = we ? d : '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t o_resp(input bit is_ldr, input bit rd, input logic [DW-1:0] data);
    out_t o = '0;
    o.busy = 1'b1;
    if (rd && is_ldr)  begin o.ldr_rvalid = 1'b1; o.ldr_rdata = data; end
    if (rd && !is_ldr) begin o.cpu_rvalid = 1'b1; o.cpu_rdata = data; end
    return o;
  endfunction

  function automatic vec_t mk_vec(input in_t s, input out_t e);
    vec_t v;
    v.stim = s; v.exp = e;
    return v;
  endfunction

  // Winner of an arbitration: 1 = loader, 0 = CPU.
  function automatic bit pick(input bit c, input bit l, input bit last_ldr);
`ifdef ARB_ROUND_ROBIN_EN
    if (c && l) return !last_ldr;
`else
    if (c && l && last_ldr) return 1'b0;
`endif
    return !c;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.cpu_gnt = cpu_gnt; o.ldr_gnt = ldr_gnt; o.cpu_rvalid = cpu_rvalid; o.ldr_rvalid = ldr_rvalid;
    o.cpu_rdata = cpu_rdata; o.ldr_rdata = ldr_rdata; o.mem_en = mem_en; o.mem_we = mem_we;
    o.mem_addr = mem_addr; o.mem_wdata = mem_wdata; o.busy = busy;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = get_out();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, required %h (gnt c/l rv c/l rdata c/l en we addr wdata busy)",
               name, $time, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    reset = v.rst;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wdata;
    ldr_req = v.l_req; ldr_we = v.l_we; ldr_addr = v.l_addr; ldr_wdata = v.l_wdata;
  endtask

  // One clock cycle: inputs applied just after the edge, outputs checked on the falling edge.
  task automatic step(input in_t v, input out_t exp, input string name);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(name, exp);
  endtask

  // One requester streams 32 accesses to addresses 0..31, re-requesting in every RESP.
  task automatic run_burst(input bit is_ldr, input bit we, input string name);
    int            idx;
    int            n_rv;
    in_t           v;
    out_t          e;
    bit            rq;
    logic [AW-1:0] a;
    idx  = 0;
    n_rv = 0;
    for (int k = 0; k < 66; k++) begin
      rq = (idx < 32);
      a  = AW'(idx);
      v  = is_ldr ? mk_in(0, 0, 0, 0, 0, rq, we, a, pat(idx))
                  : mk_in(0, rq, we, a, pat(idx), 0, 0, 0, 0);
      if (k == 0 || k == 65) begin
        e = o_none();
      end else if (k % 2 == 1) begin
        e = o_gnt(is_ldr, we, AW'((k - 1) / 2), pat((k - 1) / 2));
        if (we) ref_mem[(k - 1) / 2] = pat((k - 1) / 2);
      end else begin
        e = o_resp(is_ldr, !we, ref_mem[(k - 2) / 2]);
      end
      step(v, e, name);
      if (cpu_rvalid || ldr_rvalid) n_rv++;
      if (k % 2 == 1) idx++;
    end
    check_cnt({name, "_rvalid_count"}, n_rv, we ? 0 : 32);
  endtask

  in_t    idle_in;
  in_t    rst_in;
  in_t    v;
  in_t    prev_in;
  out_t   e;
  grant_t gr_prev, gr_now;
  bit     last_ldr, rsp, w, rq;
  bit            pend [2];
  bit            pwe  [2];
  logic [AW-1:0] pa   [2];
  logic [DW-1:0] pd   [2];

  initial begin
    idle_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_in  = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(rst_in);
    for (int i = 0; i < 32; i++) ref_mem[i] = 'x;

    // Reset state: every output low.
    step(rst_in, o_none(), "reset_0");
    step(rst_in, o_none(), "reset_1");

    // Loader preloads the whole memory with back-to-back writes.
    run_burst(1'b1, 1'b1, "preload");

    tbl[0] = mk_vec(mk_in(0, 1, 0, 5'h03, 0, 0, 0, 0, 0),     o_none());
    tbl[1] = mk_vec(mk_in(0, 1, 0, 5'h03, 0, 0, 0, 0, 0),     o_gnt(0, 0, 5'h03, 0));
    tbl[2] = mk_vec(idle_in,                                  o_resp(0, 1, 8'hA5));
    tbl[3] = mk_vec(idle_in,                                  o_none());
    tbl[4] = mk_vec(mk_in(0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C), o_none());
    tbl[5] = mk_vec(mk_in(0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C), o_gnt(1, 1, 5'h1F, 8'h3C));
    tbl[6] = mk_vec(mk_in(0, 1, 0, 5'h1F, 0, 0, 0, 0, 0),     o_resp(1, 0, 0));
    tbl[7] = mk_vec(mk_in(0, 1, 0, 5'h1F, 0, 0, 0, 0, 0),     o_gnt(0, 0, 5'h1F, 0));
    tbl[8] = mk_vec(idle_in,                                  o_resp(0, 1, 8'h3C));
    tbl[9] = mk_vec(idle_in,                                  o_none());
    for (int i = 0; i < 10; i++) step(tbl[i].stim, tbl[i].exp, $sformatf("table[%0d]", i));
    ref_mem[31] = 8'h3C;

    // Reset during ACCESS of a read: aborted, no rvalid afterwards.
    step(mk_in(0, 1, 0, 5'h03, 0, 0, 0, 0, 0), o_none(), "abort_idle");
    step(mk_in(1, 1, 0, 5'h03, 0, 0, 0, 0, 0), o_gnt(0, 0, 5'h03, 0), "abort_access");
    step(idle_in, o_none(), "abort_after_reset");
    step(idle_in, o_none(), "abort_no_rvalid");

    // Both requesters asserting continuously, CPU reads addr 2, loader reads addr 4.
    for (int k = 0; k < 12; k++) begin
      int j;
      rq = (k < 10);
      v  = mk_in(0, rq, 0, 5'h02, 0, rq, 0, 5'h04, 0);
      j  = (k % 2 == 1) ? (k - 1) / 2 : (k - 2) / 2;
`ifdef ARB_ROUND_ROBIN_EN
      w = (j % 2 == 1);
`else
      w = 1'b0;
`endif
      if (k == 0 || k == 11) e = o_none();
      else if (k % 2 == 1)   e = o_gnt(w, 0, w ? 5'h04 : 5'h02, 0);
      else                   e = o_resp(w, 1, ref_mem[w ? 4 : 2]);
      step(v, e, $sformatf("contention[%0d]", k));
    end

    // CPU back-to-back reads over the whole address range.
    run_burst(1'b0, 1'b0, "b2b_read");

    for (int k = 0; k < 100; k++) step(idle_in, o_none(), "idle_bus");

    // Randomized traffic against a transaction-timing model.
    step(rst_in, o_none(), "rand_sync");
    prev_in  = rst_in;
    gr_prev  = '0;
    last_ldr = 1'b1;
    for (int r = 0; r < 2; r++) begin pend[r] = 0; pwe[r] = 0; pa[r] = '0; pd[r] = '0; end
    for (int c = 0; c < 3000; c++) begin
      // A request seen in a non-grant cycle without reset is granted in the next cycle.
      gr_now = '0;
      if (!prev_in.rst && !gr_prev.v && (prev_in.c_req || prev_in.l_req)) begin
        w         = pick(prev_in.c_req, prev_in.l_req, last_ldr);
        gr_now.v  = 1'b1;
        gr_now.ldr = w;
        gr_now.we = w ? prev_in.l_we    : prev_in.c_we;
        gr_now.a  = w ? prev_in.l_addr  : prev_in.c_addr;
        gr_now.d  = w ? prev_in.l_wdata : prev_in.c_wdata;
      end
      if (prev_in.rst)   last_ldr = 1'b1;
      else if (gr_now.v) last_ldr = gr_now.ldr;
      rsp = gr_prev.v && !prev_in.rst;
      e = o_none();
      if (gr_now.v) e = o_gnt(gr_now.ldr, gr_now.we, gr_now.a, gr_now.d);
      else if (rsp) e = o_resp(gr_prev.ldr, !gr_prev.we, ref_mem[gr_prev.a]);
      if (gr_now.v && gr_now.we) ref_mem[gr_now.a] = gr_now.d;

      for (int r = 0; r < 2; r++) begin
        if (gr_prev.v && (gr_prev.ldr == r[0])) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pwe[r]  = 1'($urandom_range(0, 1));
          pa[r]   = AW'($urandom_range(0, 31));
          pd[r]   = DW'($urandom_range(0, 255));
        end
      end
      v = mk_in($urandom_range(0, 39) == 0, pend[0], pwe[0], pa[0], pd[0],
                pend[1], pwe[1], pa[1], pd[1]);
      step(v, e, "random");
      prev_in = v;
      gr_prev = gr_now;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
